adapt_seq: RTL and testbench
============================

ADAPT_SEQ -- requirements
Module: adapt_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of all programmable length fields and the internal down-counter.
REQ-002 SHALL have parameter RST_LEN, default 4: number of cycles core_rstb is held low per sequence, valid range 1..255.
REQ-003 SHALL have port clk_master, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstb, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: sequence request, sampled each edge.
REQ-006 SHALL have port abort, input, 1: terminates any running sequence.
REQ-007 SHALL have port periodic, input, 1: when 1, re-adapts forever; when 0, runs one adapt window.
REQ-008 SHALL have port frame_sync, input, 1: one-cycle pulse at gray-counter wrap; aligns the adapt window.
REQ-009 SHALL have port settle_len, input, CNT_W: SETTLE duration in cycles.
REQ-010 SHALL have port adapt_len, input, CNT_W: ADAPT duration in cycles.
REQ-011 SHALL have port hold_len, input, CNT_W: HOLD duration in cycles.
REQ-012 SHALL have port ud_en, output, 1: feedback update enable to all fb cores.
REQ-013 SHALL have port core_rstb, output, 1: active-low reset to the cores.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-016 SHALL have port state, output, 3: current state encoding.
REQ-017 SHALL have port adapt_count, output, 8: number of completed adapt windows, saturating.

Function
REQ-018 SHALL implement states IDLE=0, CORE_RST=1, SETTLE=2, WAIT_SYNC=3, ADAPT=4, HOLD=5; codes 6 and 7 SHALL go to IDLE on the next edge.
REQ-019 SHALL, in IDLE, on start=1 and abort=0, enter CORE_RST and capture settle_len, adapt_len, hold_len and periodic into shadow registers; later input changes SHALL NOT affect the running sequence.
REQ-020 SHALL occupy each timed state for exactly L cycles: L=RST_LEN for CORE_RST, L=max(len,1) for SETTLE, ADAPT and HOLD (a length of 0 is treated as 1).
REQ-021 SHALL step CORE_RST to SETTLE, and SETTLE to WAIT_SYNC.
REQ-022 SHALL, in WAIT_SYNC, enter ADAPT on the edge that samples frame_sync=1, and wait indefinitely otherwise.
REQ-023 SHALL, at the end of ADAPT, go to HOLD if shadow periodic=1; otherwise go to IDLE and assert done for exactly the first IDLE cycle.
REQ-024 SHALL step HOLD to WAIT_SYNC.
REQ-025 SHALL drive ud_en=1 exactly while state==ADAPT, from a flop updated on the same edge as the state, and 0 otherwise.
REQ-026 SHALL drive core_rstb=0 exactly while state==CORE_RST, and 1 otherwise.
REQ-027 SHALL drive busy=1 whenever state!=IDLE.
REQ-028 SHALL increment adapt_count on each ADAPT exit, saturating at 255; it SHALL be cleared on entry to CORE_RST.
REQ-029 SHALL, on abort=1 in any non-IDLE state, go to IDLE on the next edge with ud_en=0, core_rstb=1 and no done pulse; adapt_count SHALL hold its value.
REQ-030 SHALL resolve start=1 and abort=1 together in IDLE as abort winning, staying in IDLE.
REQ-031 SHALL ignore start while busy=1.
REQ-032 SHALL ignore frame_sync outside WAIT_SYNC.

Reset
REQ-033 SHALL, while rstb=0, immediately force state=IDLE, ud_en=0, core_rstb=1, busy=0, done=0, adapt_count=0, and clear the counter and shadow registers.
REQ-034 SHALL, on reset assertion mid-ADAPT, drop ud_en asynchronously within the same cycle.
REQ-035 SHALL resume operation on the first rising edge after rstb deasserts, starting in IDLE.

Verification
REQ-036 SHALL cover single shot: periodic=0, settle=10, adapt=100, start pulse, frame_sync 3 cycles after SETTLE ends -> core_rstb low 4 cycles, ud_en high exactly 100 cycles, one done pulse, adapt_count=1.
REQ-037 SHALL cover periodic mode: periodic=1, adapt=20, hold=50, frame_sync every 128 cycles -> ud_en high 20 cycles once per 128-cycle frame, adapt_count=5 after 5 windows, no done pulse.
REQ-038 SHALL cover zero lengths: settle=adapt=0 -> each state lasts 1 cycle; ud_en high for 1 cycle.
REQ-039 SHALL cover abort: abort at cycle 40 of a 100-cycle ADAPT -> state=0 and ud_en=0 at the next edge, no done pulse, adapt_count unchanged.
REQ-040 SHALL cover start/abort collision and start while busy: start and abort together in IDLE -> stays IDLE; start during SETTLE -> no restart and adapt_count is not cleared.
REQ-041 SHALL cover async reset: rstb low between clock edges during ADAPT -> ud_en=0 before the next edge, and all outputs at their reset values.

Source files
------------

// File: rtl/adapt_seq.sv
// Adaptation sequencer: resets the feedback cores, lets them settle, then
// opens frame-aligned adapt windows (once, or forever with a hold gap).
`timescale 1ns/1ps
module adapt_seq #(
  parameter int CNT_W   = 16,
  parameter int RST_LEN = 4
) (
  input  logic             clk_master,
  input  logic             rstb,
  input  logic             start,
  input  logic             abort,
  input  logic             periodic,
  input  logic             frame_sync,
  input  logic [CNT_W-1:0] settle_len,
  input  logic [CNT_W-1:0] adapt_len,
  input  logic [CNT_W-1:0] hold_len,
  output logic             ud_en,
  output logic             core_rstb,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state,
  output logic [7:0]       adapt_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CORE_RST  = 3'd1,
    SETTLE    = 3'd2,
    WAIT_SYNC = 3'd3,
    ADAPT     = 3'd4,
    HOLD      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] settle_sh_q, settle_sh_d;
  logic [CNT_W-1:0] adapt_sh_q, adapt_sh_d;
  logic [CNT_W-1:0] hold_sh_q, hold_sh_d;
  logic             periodic_sh_q, periodic_sh_d;
  logic [7:0]       adapt_count_q, adapt_count_d;
  logic             done_q, done_d;
  logic             ud_en_q;
  logic             cnt_zero;

  // The counter holds "cycles left after this one", so a zero length
  // collapses to a single-cycle stay just like a length of one.
  function automatic logic [CNT_W-1:0] last_of(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : (len - ONE);
  endfunction

  assign cnt_zero = (cnt_q == '0);

  // Next-state, counter, shadow and completion logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    settle_sh_d   = settle_sh_q;
    adapt_sh_d    = adapt_sh_q;
    hold_sh_d     = hold_sh_q;
    periodic_sh_d = periodic_sh_q;
    adapt_count_d = adapt_count_q;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d       = CORE_RST;
          cnt_d         = RST_LAST;
          settle_sh_d   = settle_len;
          adapt_sh_d    = adapt_len;
          hold_sh_d     = hold_len;
          periodic_sh_d = periodic;
          adapt_count_d = '0;
        end
      end
      CORE_RST: begin
        if (cnt_zero) begin
          state_d = SETTLE;
          cnt_d   = last_of(settle_sh_q);
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          state_d = WAIT_SYNC;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      WAIT_SYNC: begin
        if (frame_sync) begin
          state_d = ADAPT;
          cnt_d   = last_of(adapt_sh_q);
        end
      end
      ADAPT: begin
        if (cnt_zero) begin
          adapt_count_d = (adapt_count_q == 8'hFF) ? 8'hFF : adapt_count_q + 8'd1;
          if (periodic_sh_q) begin
            state_d = HOLD;
            cnt_d   = last_of(hold_sh_q);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_d = WAIT_SYNC;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides everything outside IDLE; the window count is kept.
    if (abort && (state_q != IDLE)) begin
      state_d       = IDLE;
      cnt_d         = '0;
      done_d        = 1'b0;
      adapt_count_d = adapt_count_q;
    end
  end

  // State, counter, shadow and status registers.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      settle_sh_q   <= '0;
      adapt_sh_q    <= '0;
      hold_sh_q     <= '0;
      periodic_sh_q <= 1'b0;
      adapt_count_q <= '0;
      done_q        <= 1'b0;
      ud_en_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      settle_sh_q   <= settle_sh_d;
      adapt_sh_q    <= adapt_sh_d;
      hold_sh_q     <= hold_sh_d;
      periodic_sh_q <= periodic_sh_d;
      adapt_count_q <= adapt_count_d;
      done_q        <= done_d;
      ud_en_q       <= (state_d == ADAPT);
    end
  end

  assign ud_en       = ud_en_q;
  assign core_rstb   = (state_q != CORE_RST);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign state       = state_q;
  assign adapt_count = adapt_count_q;

endmodule

// File: tb/tb_adapt_seq.sv
// Bench for adapt_seq: phase/elapsed-time reference model compared every
// cycle, directed scenarios with hand-computed totals, then random traffic.
`timescale 1ns/1ps
module tb_adapt_seq;

  localparam int CNT_W   = 16;
  localparam int RST_LEN = 4;

  localparam int P_IDLE = 0, P_RST = 1, P_SETTLE = 2, P_WAIT = 3, P_ADAPT = 4, P_HOLD = 5;

  logic             clk_master = 1'b0;
  logic             rstb = 1'b0;
  logic             start = 1'b0, abort = 1'b0, periodic = 1'b0, frame_sync = 1'b0;
  logic [CNT_W-1:0] settle_len = '0, adapt_len = '0, hold_len = '0;
  logic             ud_en, core_rstb, busy, done;
  logic [2:0]       state;
  logic [7:0]       adapt_count;

  int checks = 0;
  int errors = 0;
  int ud_cyc = 0, rstlow_cyc = 0, done_cnt = 0, settle_cyc = 0;

  adapt_seq #(.CNT_W(CNT_W), .RST_LEN(RST_LEN)) dut (
    .clk_master (clk_master),
    .rstb       (rstb),
    .start      (start),
    .abort      (abort),
    .periodic   (periodic),
    .frame_sync (frame_sync),
    .settle_len (settle_len),
    .adapt_len  (adapt_len),
    .hold_len   (hold_len),
    .ud_en      (ud_en),
    .core_rstb  (core_rstb),
    .busy       (busy),
    .done       (done),
    .state      (state),
    .adapt_count(adapt_count)
  );

  always #5 clk_master = ~clk_master;

  // Reference model: which phase we are in, how long we have been there,
  // and the sequence settings latched at start.
  typedef struct packed {
    int phase;
    int elapsed;
    int sh_settle;
    int sh_adapt;
    int sh_hold;
    bit sh_per;
    int count;
    bit done;
  } mstate_t;

  mstate_t m;

  function automatic int at_least_one(input int v);
    return (v > 1) ? v : 1;
  endfunction

  function automatic mstate_t step(input mstate_t cur, input bit st, input bit ab, input bit fs,
                                   input int se, input int ad, input int ho, input bit pe);
    mstate_t n;
    int dur;
    n = cur;
    n.done = 1'b0;
    case (cur.phase)
      P_RST:    dur = RST_LEN;
      P_SETTLE: dur = at_least_one(cur.sh_settle);
      P_ADAPT:  dur = at_least_one(cur.sh_adapt);
      P_HOLD:   dur = at_least_one(cur.sh_hold);
      default:  dur = 1;
    endcase
    if (cur.phase != P_IDLE && ab) begin
      n.phase = P_IDLE;
      n.elapsed = 0;
      return n;
    end
    if (cur.phase == P_IDLE) begin
      if (st && !ab) begin
        n.phase = P_RST; n.elapsed = 0; n.count = 0;
        n.sh_settle = se; n.sh_adapt = ad; n.sh_hold = ho; n.sh_per = pe;
      end
    end else if (cur.phase == P_WAIT) begin
      if (fs) begin n.phase = P_ADAPT; n.elapsed = 0; end
    end else begin
      n.elapsed = cur.elapsed + 1;
      if (n.elapsed == dur) begin
        n.elapsed = 0;
        if (cur.phase == P_RST) n.phase = P_SETTLE;
        else if (cur.phase == P_SETTLE || cur.phase == P_HOLD) n.phase = P_WAIT;
        else begin
          n.count = (cur.count < 255) ? cur.count + 1 : 255;
          if (cur.sh_per) n.phase = P_HOLD;
          else begin n.phase = P_IDLE; n.done = 1'b1; end
        end
      end
    end
    return n;
  endfunction

  // Model advances on the same edges as the DUT, including async reset.
  always @(posedge clk_master or negedge rstb) begin
    if (!rstb) m <= '0;
    else m <= step(m, start, abort, frame_sync, int'(settle_len), int'(adapt_len),
                   int'(hold_len), periodic);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model plus output-activity tallies.
  always @(negedge clk_master) begin
    chk("state", int'(state), m.phase);
    chk("ud_en", int'(ud_en), int'(m.phase == P_ADAPT));
    chk("core_rstb", int'(core_rstb), int'(m.phase != P_RST));
    chk("busy", int'(busy), int'(m.phase != P_IDLE));
    chk("done", int'(done), int'(m.done));
    chk("adapt_count", int'(adapt_count), m.count);
    ud_cyc     += int'(ud_en);
    rstlow_cyc += int'(!core_rstb);
    done_cnt   += int'(done);
    settle_cyc += int'(state == 3'd2);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_master);
      #2;
    end
  endtask

  task automatic clr_tally();
    ud_cyc = 0; rstlow_cyc = 0; done_cnt = 0; settle_cyc = 0;
  endtask

  task automatic wait_for(input int s, input int cnt, input int budget, input string nm);
    int n = 0;
    while (!(int'(state) == s && (cnt < 0 || int'(adapt_count) == cnt)) && n < budget) begin
      tick(1);
      n++;
    end
    chk(nm, int'(state), s);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    rstb = 1'b0;
    tick(3);
    chk("reset_state", int'(state), 0);
    chk("reset_core_rstb", int'(core_rstb), 1);
    chk("reset_count", int'(adapt_count), 0);
    rstb = 1'b1;
    tick(2);

    // Single shot: settle 10, adapt 100.
    clr_tally();
    periodic = 1'b0; settle_len = 16'd10; adapt_len = 16'd100; hold_len = 16'd7;
    pulse_start();
    settle_len = 16'd3; adapt_len = 16'd9;
    tick(17);
    frame_sync = 1'b1; tick(1); frame_sync = 1'b0;
    tick(150);
    chk("single_rst_low", rstlow_cyc, 4);
    chk("single_ud_cycles", ud_cyc, 100);
    chk("single_done", done_cnt, 1);
    chk("single_count", int'(adapt_count), 1);
    $display("test single_shot finished");

    // Periodic: adapt 20, hold 50, frame every 128; start while busy ignored.
    clr_tally();
    periodic = 1'b1; settle_len = 16'd5; adapt_len = 16'd20; hold_len = 16'd50;
    pulse_start();
    tick(20);
    for (int k = 0; k < 5; k++) begin
      frame_sync = 1'b1;
      if (k == 2) start = 1'b1;
      tick(1);
      frame_sync = 1'b0; start = 1'b0;
      tick(127);
    end
    chk("periodic_ud_cycles", ud_cyc, 100);
    chk("periodic_count", int'(adapt_count), 5);
    chk("periodic_done", done_cnt, 0);
    chk("periodic_state", int'(state), 3);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("periodic_abort_state", int'(state), 0);
    $display("test periodic finished");

    // Zero lengths: every timed state collapses to one cycle.
    clr_tally();
    periodic = 1'b0; settle_len = '0; adapt_len = '0; hold_len = '0;
    frame_sync = 1'b1;
    pulse_start();
    tick(12);
    frame_sync = 1'b0;
    chk("zero_rst_low", rstlow_cyc, 4);
    chk("zero_settle", settle_cyc, 1);
    chk("zero_ud_cycles", ud_cyc, 1);
    chk("zero_done", done_cnt, 1);
    $display("test zero_lengths finished");

    // Abort at cycle 40 of the second 100-cycle adapt window.
    periodic = 1'b1; settle_len = 16'd1; adapt_len = 16'd100; hold_len = 16'd3;
    frame_sync = 1'b1;
    pulse_start();
    wait_for(4, 1, 400, "abort_reach_adapt");
    tick(39);
    abort = 1'b1; tick(1); abort = 1'b0;
    frame_sync = 1'b0;
    chk("abort_state", int'(state), 0);
    chk("abort_ud_en", int'(ud_en), 0);
    chk("abort_count", int'(adapt_count), 1);
    clr_tally();
    tick(5);
    chk("abort_no_done", done_cnt, 0);
    $display("test abort finished");

    // Start/abort collision in IDLE, then start during SETTLE.
    start = 1'b1; abort = 1'b1; tick(1); start = 1'b0; abort = 1'b0;
    chk("collision_state", int'(state), 0);
    chk("collision_busy", int'(busy), 0);
    periodic = 1'b0; settle_len = 16'd20; adapt_len = 16'd5;
    pulse_start();
    wait_for(2, -1, 20, "busy_reach_settle");
    start = 1'b1; tick(3); start = 1'b0;
    chk("busy_start_state", int'(state), 2);
    chk("busy_start_core_rstb", int'(core_rstb), 1);
    frame_sync = 1'b1; tick(40); frame_sync = 1'b0;
    chk("busy_start_final_count", int'(adapt_count), 1);
    $display("test collision_busy finished");

    // Asynchronous reset between edges during ADAPT.
    periodic = 1'b0; settle_len = 16'd1; adapt_len = 16'd50;
    frame_sync = 1'b1;
    pulse_start();
    wait_for(4, -1, 100, "async_reach_adapt");
    tick(5);
    #1 rstb = 1'b0;
    #1;
    chk("async_ud_en", int'(ud_en), 0);
    chk("async_state", int'(state), 0);
    chk("async_core_rstb", int'(core_rstb), 1);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    chk("async_count", int'(adapt_count), 0);
    tick(2);
    rstb = 1'b1;
    frame_sync = 1'b0;
    tick(2);
    pulse_start();
    chk("resume_core_rstb", int'(core_rstb), 0);
    abort = 1'b1; tick(1); abort = 1'b0;
    $display("test async_reset finished");

    // Random traffic, including changing lengths mid-sequence and resets.
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom_range(0, 11) == 0);
      abort      = ($urandom_range(0, 59) == 0);
      frame_sync = ($urandom_range(0, 5) == 0);
      periodic   = $urandom_range(0, 1) == 1;
      settle_len = CNT_W'($urandom_range(0, 5));
      adapt_len  = CNT_W'($urandom_range(0, 6));
      hold_len   = CNT_W'($urandom_range(0, 4));
      if (i % 997 == 500) begin
        #1 rstb = 1'b0;
        tick(1);
        rstb = 1'b1;
      end else begin
        tick(1);
      end
    end
    start = 1'b0; abort = 1'b0; frame_sync = 1'b0;
    tick(2);
    $display("test random finished");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
